hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32IM core. It works alongside the operand-forwarding logic and handles the hazards forwarding cannot resolve:
- load-use dependencies, with a one-cycle stall and bubble;
- taken branch/jump redirects, by flushing D and X;
- multi-cycle M-extension operations, with a start/done handshake to the MDU that holds the front of the pipeline until the result is ready.

It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_ctrl_if.sv | 29 ++
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the 5-stage pipeline datapath and the hazard controller.
// The datapath side is master; hazard_ctrl is slave.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr_D;
    logic [31:0]      instr_X;
    logic             RegWEn_X;
    logic             br_taken_X;
    logic             mdu_done;
    logic             mdu_start;
    logic             stall_F;
    logic             stall_D;
    logic             stall_X;
    logic             flush_D;
    logic             flush_X;
    logic             flush_M;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output instr_D, instr_X, RegWEn_X, br_taken_X, mdu_done,
        input  mdu_start, stall_F, stall_D, stall_X, flush_D, flush_X, flush_M, stall_cnt
    );

    modport slave (
        input  instr_D, instr_X, RegWEn_X, br_taken_X, mdu_done,
        output mdu_start, stall_F, stall_D, stall_X, flush_D, flush_X, flush_M, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, branch redirect flush, and MDU start/done hold,
// plus a saturating count of cycles with the PC held.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, MDU_WAIT} state_t;

    localparam logic [31:0] MASK_OPC  = 32'h0000_007F;
    localparam logic [31:0] MASK_F7   = 32'hFE00_0000;
    localparam logic [31:0] OPC_LOAD  = 32'h0000_0003;
    localparam logic [31:0] OPC_OP    = 32'h0000_0033;
    localparam logic [31:0] OPC_STORE = 32'h0000_0023;
    localparam logic [31:0] OPC_BR    = 32'h0000_0063;
    localparam logic [31:0] OPC_LUI   = 32'h0000_0037;
    localparam logic [31:0] OPC_AUIPC = 32'h0000_0017;
    localparam logic [31:0] OPC_JAL   = 32'h0000_006F;
    localparam logic [31:0] MDU_MATCH = 32'h0200_0033;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [31:0] opc_word_D;
    logic [4:0]  rs1_D, rs2_D, rd_X;
    logic        rs1_used, rs2_used;
    logic        is_load_X, is_mdu_X, load_use;

    logic mdu_start, stall_F, stall_D, stall_X, flush_D, flush_X, flush_M;

    // Opcodes are compared as whole masked words so every instruction bit is referenced.
    assign opc_word_D = bus.instr_D & MASK_OPC;
    assign rs1_D      = bus.instr_D[19:15];
    assign rs2_D      = bus.instr_D[24:20];
    assign rd_X       = bus.instr_X[11:7];

    assign rs1_used  = !(opc_word_D inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign rs2_used  = opc_word_D inside {OPC_OP, OPC_STORE, OPC_BR};
    assign is_load_X = (bus.instr_X & MASK_OPC) == OPC_LOAD;
    assign is_mdu_X  = (bus.instr_X & (MASK_F7 | MASK_OPC)) == MDU_MATCH;

    assign load_use = is_load_X && bus.RegWEn_X && (rd_X != 5'd0) &&
                      ((rs1_used && (rs1_D == rd_X)) || (rs2_used && (rs2_D == rd_X)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (!bus.br_taken_X && is_mdu_X) state_d = MDU_WAIT;
            MDU_WAIT: if (bus.mdu_done)                state_d = RUN;
            default:                                   state_d = RUN;
        endcase
    end

    // Branch squashes the D instruction, so it outranks both MDU launch and load-use.
    always_comb begin
        mdu_start = 1'b0;
        stall_F   = 1'b0;
        stall_D   = 1'b0;
        stall_X   = 1'b0;
        flush_D   = 1'b0;
        flush_X   = 1'b0;
        flush_M   = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (bus.br_taken_X) begin
                        flush_D = 1'b1;
                        flush_X = 1'b1;
                    end else if (is_mdu_X) begin
                        mdu_start = 1'b1;
                        stall_F   = 1'b1;
                        stall_D   = 1'b1;
                        stall_X   = 1'b1;
                        flush_M   = 1'b1;
                    end else if (load_use) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_X = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (!bus.mdu_done) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        stall_X = 1'b1;
                        flush_M = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_F && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    assign bus.mdu_start = mdu_start;
    assign bus.stall_F   = stall_F;
    assign bus.stall_D   = stall_D;
    assign bus.stall_X   = stall_X;
    assign bus.flush_D   = flush_D;
    assign bus.flush_X   = flush_X;
    assign bus.flush_M   = flush_M;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one task per scenario, inline checks against
// hand-computed control vectors {mdu_start,stall_F,stall_D,stall_X,flush_D,flush_X,flush_M}.
module tb_hazard_ctrl;
    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [31:0] LW_X5       = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] LW_X0       = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
    localparam logic [31:0] ADD_X6_2_5  = {7'd0, 5'd5, 5'd2, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_X6_0_0  = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] LUI_X5      = {20'h00028, 5'd5, 7'b0110111};
    localparam logic [31:0] ADDI_X6_5   = {12'd1, 5'd5, 3'd0, 5'd6, 7'b0010011};
    localparam logic [31:0] MUL_X7_1_2  = {7'b0000001, 5'd2, 5'd1, 3'd0, 5'd7, 7'b0110011};

    localparam logic [6:0] C_IDLE  = 7'b000_0000;
    localparam logic [6:0] C_LU    = 7'b011_0010;
    localparam logic [6:0] C_BR    = 7'b000_0110;
    localparam logic [6:0] C_START = 7'b111_1001;
    localparam logic [6:0] C_WAIT  = 7'b011_1001;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) bus ();
    hazard_ctrl_if #(.CNT_W(2))  bus2 ();

    hazard_ctrl #(.CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bus));
    hazard_ctrl #(.CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bus2));

    logic [6:0] ctrl;
    assign ctrl = {bus.mdu_start, bus.stall_F, bus.stall_D, bus.stall_X,
                   bus.flush_D, bus.flush_X, bus.flush_M};

    task automatic drive(input logic [31:0] ix, input logic [31:0] id, input logic we,
                         input logic br, input logic done);
        bus.instr_X    = ix;
        bus.instr_D    = id;
        bus.RegWEn_X   = we;
        bus.br_taken_X = br;
        bus.mdu_done   = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(LW_X5, ADD_X6_2_5, 1'b1, 1'b1, 1'b1);
        bus2.instr_X = NOP; bus2.instr_D = NOP; bus2.RegWEn_X = 1'b0;
        bus2.br_taken_X = 1'b0; bus2.mdu_done = 1'b0;
        #2;
        vec_cnt++;
        if (ctrl !== C_IDLE) begin err_cnt++; $display("FAIL rst_ctrl_lu got=%b exp=%b", ctrl, C_IDLE); end
        drive(MUL_X7_1_2, NOP, 1'b1, 1'b0, 1'b0);
        #1;
        vec_cnt++;
        if (ctrl !== C_IDLE) begin err_cnt++; $display("FAIL rst_ctrl_mul got=%b exp=%b", ctrl, C_IDLE); end
        vec_cnt++;
        if (bus.stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL rst_cnt got=%0d exp=0", bus.stall_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vec_cnt++;
        if (ctrl !== C_IDLE) begin err_cnt++; $display("FAIL rst_release_ctrl got=%b exp=%b", ctrl, C_IDLE); end
        $display("reset: ctrl=%b cnt=%0d", ctrl, bus.stall_cnt);
    endtask

    task automatic test_load_use_rs2();
        @(posedge clk); #1;
        drive(LW_X5, ADD_X6_2_5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        vec_cnt++;
        if (ctrl !== C_LU) begin err_cnt++; $display("FAIL lu_rs2_ctrl got=%b exp=%b", ctrl, C_LU); end
        @(posedge clk); #1;
        drive(NOP, ADD_X6_2_5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vec_cnt++;
        if (ctrl !== C_IDLE) begin err_cnt++; $display("FAIL lu_rs2_one_cycle got=%b exp=%b", ctrl, C_IDLE); end
        vec_cnt++;
        if (bus.stall_cnt !== 16'd1) begin err_cnt++; $display("FAIL lu_rs2_cnt got=%0d exp=1", bus.stall_cnt); end
        $display("load_use_rs2: ctrl=%b cnt=%0d", ctrl, bus.stall_cnt);
    endtask

    task automatic test_no_hazard();
        @(posedge clk); #1;
        drive(LW_X0, ADD_X6_0_0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        vec_cnt++;
        if (ctrl !== C_IDLE) begin err_cnt++; $display("FAIL lw_x0_ctrl got=%b exp=%b", ctrl, C_IDLE); end
        @(posedge clk); #1;
        drive(LW_X5, LUI_X5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        vec_cnt++;
        if (ctrl !== C_IDLE) begin err_cnt++; $display("FAIL lw_lui_ctrl got=%b exp=%b", ctrl, C_IDLE); end
        @(posedge clk); #1;
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vec_cnt++;
        if (bus.stall_cnt !== 16'd1) begin err_cnt++; $display("FAIL no_hazard_cnt got=%0d exp=1", bus.stall_cnt); end
        $display("no_hazard: ctrl=%b cnt=%0d", ctrl, bus.stall_cnt);
    endtask

    task automatic test_branch_load_use();
        @(posedge clk); #1;
        drive(LW_X5, ADD_X6_2_5, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        vec_cnt++;
        if (ctrl !== C_BR) begin err_cnt++; $display("FAIL br_lu_ctrl got=%b exp=%b", ctrl, C_BR); end
        @(posedge clk); #1;
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vec_cnt++;
        if (bus.stall_cnt !== 16'd1) begin err_cnt++; $display("FAIL br_lu_cnt got=%0d exp=1", bus.stall_cnt); end
        $display("branch_load_use: ctrl=%b cnt=%0d", ctrl, bus.stall_cnt);
    endtask

    // Start cycle, three wait cycles (one with a stray branch), done in the fifth cycle.
    task automatic test_mdu();
        int starts = 0;
        logic [6:0] exp_seq [5] = '{C_START, C_WAIT, C_WAIT, C_WAIT, C_IDLE};
        logic       done_seq[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       br_seq  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(MUL_X7_1_2, NOP, 1'b1, br_seq[i], done_seq[i]);
            @(negedge clk);
            if (bus.mdu_start) starts++;
            vec_cnt++;
            if (ctrl !== exp_seq[i]) begin err_cnt++; $display("FAIL mdu_ctrl[%0d] got=%b exp=%b", i, ctrl, exp_seq[i]); end
        end
        vec_cnt++;
        if (starts !== 1) begin err_cnt++; $display("FAIL mdu_start_pulses got=%0d exp=1", starts); end
        @(posedge clk); #1;
        drive(NOP, NOP, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        vec_cnt++;
        if (ctrl !== C_IDLE) begin err_cnt++; $display("FAIL mdu_spurious_done got=%b exp=%b", ctrl, C_IDLE); end
        vec_cnt++;
        if (bus.stall_cnt !== 16'd5) begin err_cnt++; $display("FAIL mdu_cnt got=%0d exp=5", bus.stall_cnt); end
        $display("mdu: starts=%0d ctrl=%b cnt=%0d", starts, ctrl, bus.stall_cnt);
    endtask

    task automatic test_back_to_back();
        logic [6:0]  exp_seq [5] = '{C_START, C_IDLE, C_START, C_IDLE, C_IDLE};
        logic [31:0] x_seq   [5] = '{MUL_X7_1_2, MUL_X7_1_2, MUL_X7_1_2, MUL_X7_1_2, NOP};
        logic        done_seq[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(x_seq[i], NOP, 1'b1, 1'b0, done_seq[i]);
            @(negedge clk);
            vec_cnt++;
            if (ctrl !== exp_seq[i]) begin err_cnt++; $display("FAIL b2b_ctrl[%0d] got=%b exp=%b", i, ctrl, exp_seq[i]); end
        end
        vec_cnt++;
        if (bus.stall_cnt !== 16'd7) begin err_cnt++; $display("FAIL b2b_cnt got=%0d exp=7", bus.stall_cnt); end
        $display("back_to_back: ctrl=%b cnt=%0d", ctrl, bus.stall_cnt);
    endtask

    task automatic test_reset_mid_mdu();
        @(posedge clk); #1;
        drive(MUL_X7_1_2, NOP, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        vec_cnt++;
        if (ctrl !== C_WAIT) begin err_cnt++; $display("FAIL rmid_wait got=%b exp=%b", ctrl, C_WAIT); end
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if (ctrl !== C_IDLE) begin err_cnt++; $display("FAIL rmid_rst_ctrl got=%b exp=%b", ctrl, C_IDLE); end
        vec_cnt++;
        if (bus.stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL rmid_rst_cnt got=%0d exp=0", bus.stall_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(NOP, NOP, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        vec_cnt++;
        if (ctrl !== C_IDLE) begin err_cnt++; $display("FAIL rmid_late_done got=%b exp=%b", ctrl, C_IDLE); end
        @(posedge clk); #1;
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vec_cnt++;
        if (ctrl !== C_IDLE) begin err_cnt++; $display("FAIL rmid_run got=%b exp=%b", ctrl, C_IDLE); end
        vec_cnt++;
        if (bus.stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL rmid_cnt got=%0d exp=0", bus.stall_cnt); end
        $display("reset_mid_mdu: ctrl=%b cnt=%0d", ctrl, bus.stall_cnt);
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus2.instr_X = LW_X5; bus2.instr_D = ADDI_X6_5; bus2.RegWEn_X = 1'b1;
            @(negedge clk);
            vec_cnt++;
            if (bus2.stall_F !== 1'b1) begin err_cnt++; $display("FAIL sat_stall[%0d] got=%b exp=1", i, bus2.stall_F); end
            @(posedge clk); #1;
            bus2.instr_X = NOP; bus2.RegWEn_X = 1'b0;
            @(negedge clk);
            vec_cnt++;
            if (bus2.stall_cnt !== exp_cnt[i]) begin err_cnt++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, bus2.stall_cnt, exp_cnt[i]); end
            $display("saturation[%0d]: cnt=%0d", i, bus2.stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use_rs2();
        test_no_hazard();
        test_branch_load_use();
        test_mdu();
        test_back_to_back();
        test_reset_mid_mdu();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
